// File: rtl/dark_bus_arbiter.sv
// Two-master round-robin arbiter for the shared on-chip memory device bus.
// Holds the bus until the slave acknowledges and aborts with an error response on timeout.
module dark_bus_arbiter #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hFFFF_FFFF
) (
    input  logic        CLK,
    input  logic        RES,

    input  logic        M0_REQ,
    input  logic        M0_WE,
    input  logic [3:0]  M0_BE,
    input  logic [31:0] M0_ADDR,
    input  logic [31:0] M0_WDATA,
    output logic        M0_ACK,
    output logic        M0_ERR,
    output logic [31:0] M0_RDATA,

    input  logic        M1_REQ,
    input  logic        M1_WE,
    input  logic [3:0]  M1_BE,
    input  logic [31:0] M1_ADDR,
    input  logic [31:0] M1_WDATA,
    output logic        M1_ACK,
    output logic        M1_ERR,
    output logic [31:0] M1_RDATA,

    output logic        S_EN,
    output logic        S_RE,
    output logic        S_WE,
    output logic [3:0]  S_BE,
    output logic [31:0] S_ADDR,
    output logic [31:0] S_WDATA,
    input  logic [31:0] S_RDATA,
    input  logic        S_RACK,
    input  logic        S_WACK,

    output logic [1:0]  GNT,
    output logic        BUSY
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    logic [1:0]  state_q,   state_d;
    logic        owner_q,   owner_d;
    logic        lastGnt_q, lastGnt_d;
    logic        we_q,      we_d;
    logic [3:0]  be_q,      be_d;
    logic [31:0] addr_q,    addr_d;
    logic [31:0] wdata_q,   wdata_d;
    logic [15:0] cnt_q,     cnt_d;
    logic        err_q,     err_d;
    logic [31:0] m0Rdata_q, m0Rdata_d;
    logic [31:0] m1Rdata_q, m1Rdata_d;
    logic [1:0]  gnt_q,     gnt_d;

    logic        pick;
    logic        ackHit;
    logic        busyState;
    logic        doneState;

    // Tie goes to whichever master did not own the previous transaction.
    always_comb begin
        if (M0_REQ && M1_REQ) begin
            pick = ~lastGnt_q;
        end else begin
            pick = M1_REQ;
        end
    end

    assign ackHit = we_q ? S_WACK : S_RACK;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        lastGnt_d = lastGnt_q;
        we_d      = we_q;
        be_d      = be_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        m0Rdata_d = m0Rdata_q;
        m1Rdata_d = m1Rdata_q;
        gnt_d     = gnt_q;

        case (state_q)
            ST_IDLE: begin
                if (M0_REQ || M1_REQ) begin
                    owner_d = pick;
                    we_d    = pick ? M1_WE    : M0_WE;
                    be_d    = pick ? M1_BE    : M0_BE;
                    addr_d  = pick ? M1_ADDR  : M0_ADDR;
                    wdata_d = pick ? M1_WDATA : M0_WDATA;
                    gnt_d   = pick ? 2'b10    : 2'b01;
                    cnt_d   = 16'd0;
                    err_d   = 1'b0;
                    state_d = ST_BUSY;
                end
            end

            ST_BUSY: begin
                cnt_d = cnt_q + 16'd1;
                if (ackHit) begin
                    err_d   = 1'b0;
                    state_d = ST_DONE;
                    if (!we_q) begin
                        if (owner_q) begin
                            m1Rdata_d = S_RDATA;
                        end else begin
                            m0Rdata_d = S_RDATA;
                        end
                    end
                end else if (cnt_q == TIMEOUT_LAST) begin
                    // An ack in the final allowed cycle still wins over the abort.
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                    if (!we_q) begin
                        if (owner_q) begin
                            m1Rdata_d = ERR_DATA;
                        end else begin
                            m0Rdata_d = ERR_DATA;
                        end
                    end
                end
            end

            ST_DONE: begin
                lastGnt_d = owner_q;
                gnt_d     = 2'b00;
                cnt_d     = 16'd0;
                state_d   = ST_IDLE;
            end

            default: begin
                gnt_d   = 2'b00;
                cnt_d   = 16'd0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            state_q   <= ST_IDLE;
            owner_q   <= 1'b0;
            lastGnt_q <= 1'b1;
            we_q      <= 1'b0;
            be_q      <= 4'd0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            cnt_q     <= 16'd0;
            err_q     <= 1'b0;
            m0Rdata_q <= 32'd0;
            m1Rdata_q <= 32'd0;
            gnt_q     <= 2'b00;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            lastGnt_q <= lastGnt_d;
            we_q      <= we_d;
            be_q      <= be_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            m0Rdata_q <= m0Rdata_d;
            m1Rdata_q <= m1Rdata_d;
            gnt_q     <= gnt_d;
        end
    end

    assign busyState = (state_q == ST_BUSY);
    assign doneState = (state_q == ST_DONE);

    // Slave side is quiet outside BUSY so stale latched values never leak onto the bus.
    assign S_EN    = busyState;
    assign S_RE    = busyState & ~we_q;
    assign S_WE    = busyState & we_q;
    assign S_BE    = busyState ? be_q    : 4'd0;
    assign S_ADDR  = busyState ? addr_q  : 32'd0;
    assign S_WDATA = busyState ? wdata_q : 32'd0;

    assign M0_ACK   = doneState & ~owner_q;
    assign M1_ACK   = doneState & owner_q;
    assign M0_ERR   = M0_ACK & err_q;
    assign M1_ERR   = M1_ACK & err_q;
    assign M0_RDATA = m0Rdata_q;
    assign M1_RDATA = m1Rdata_q;

    assign GNT  = gnt_q;
    assign BUSY = busyState | doneState;

endmodule
